cline_scheduler: RTL and testbench
==================================

CLINE_SCHEDULER -- requirements
Module: cline_scheduler

Interface
REQ-001 Parameter: AGE_LIMIT, default 8, number of lost IDLE arbitrations after which a pending prefetch wins.
REQ-002 Clocking: one clock; reset is asynchronous and active-low (clk, reset_n).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 i_read  in  1  instruction line read request; i_addr  in  32  its byte address.
REQ-006 i_resp  out  1  instruction completion; i_rdata  out  256  instruction line data.
REQ-007 d_read, d_write  in  1 each  data line request, mutually exclusive; d_addr  in  32; d_wdata  in  256.
REQ-008 d_resp  out  1  data completion; d_rdata  out  256  data line data.
REQ-009 pf_req  in  1  prefetch read request; pf_addr  in  32; pf_done  out  1  prefetch completion.
REQ-010 cl_read, cl_write  out  1 each; cl_addr  out  32; cl_wdata  out  256  (toward cacheline adaptor).
REQ-011 cl_rdata  in  256; cl_resp  in  1  adaptor completion.

Function
REQ-012 FSM: IDLE, BUSY; one transaction outstanding at a time.
REQ-013 IDLE with any request: latch winner, address (bits [4:0] forced 0), wdata and op; enter BUSY next edge.
REQ-014 cl_read/cl_write/cl_addr/cl_wdata are registered; first asserted the cycle after the IDLE decision; held constant until the cl_resp cycle.
REQ-015 Arbitration: aged prefetch first; else when i and d both request, the one not granted last (rr pointer, reset to data-first); else the sole i/d requester; else prefetch.
REQ-016 Aged means ARB_AGING_EN is defined, age_cnt >= AGE_LIMIT, and pf_req = 1.
REQ-017 rr pointer updates only on i or d grants.
REQ-018 BUSY, cl_resp=1: pulse winner's resp (i_resp/d_resp/pf_done) that same cycle, combinationally; return to IDLE next edge.
REQ-019 i_rdata and d_rdata carry cl_rdata whenever matching resp is high; otherwise don't-care.
REQ-020 Merge: BUSY with prefetch winner, i_read=1 and i_addr[31:5] == latched addr[31:5] sets a merge flag.
REQ-021 With merge set, completion pulses pf_done and i_resp together; flag clears on return to IDLE; IDLE then treats i_read as new.
REQ-022 Requests seen in BUSY are ignored except for merge; requesters hold requests until their resp.
REQ-023 cl_resp in IDLE is ignored.
REQ-024 Back-to-back: a request present in the IDLE cycle after completion is granted; minimum gap between cl ops is one cycle.

Reset
REQ-025 reset_n low forces IDLE, all outputs 0, age_cnt 0, merge flag 0, rr pointer data-first, immediately, including mid-transaction.
REQ-026 An in-flight adaptor transaction is abandoned; adaptor is reset from the same reset_n.

Configuration
REQ-027 ARB_AGING_EN defined: age_cnt increments, saturating, on each IDLE decision where pf_req=1 and prefetch loses; it clears on prefetch grant or pf_req=0.
REQ-028 ARB_AGING_EN undefined: no counter; prefetch is strictly lowest priority; AGE_LIMIT is unused.

Structure
REQ-029 Shared package cline_arb_pkg holds the FSM state enum, the winner enum (W_NONE, W_INST, W_DATA, W_PF) and the 256-bit line typedef.
REQ-030 One sub-module, rr_pick2: two-requester round-robin picker with a pointer register.

Verification
REQ-031 i_read, i_addr=0x6000_0044, cl_resp 4 cycles later -> cl_addr=0x6000_0040, cl_read 1, i_resp single pulse with cl_rdata.
REQ-032 i_read and d_write rise together, twice in a row -> order data, inst, data, inst; cl_write only during data ops.
REQ-033 ARB_AGING_EN, AGE_LIMIT=8, i/d saturate while pf_req held -> prefetch wins at the 9th IDLE decision.
REQ-034 Prefetch 0x100 in flight, i_read 0x11C arrives -> one cl_read total; pf_done and i_resp in the same cycle.
REQ-035 reset_n low during BUSY data write -> cl_write 0 asynchronously; after release, pending i_read granted with cl_read one cycle later.

Source files
------------

// File: rtl/cline_arb_pkg.sv
// ---------------------------------------------------------------------------
// cline_arb_pkg
// Shared types for the cacheline scheduler:
//   state_t  - scheduler FSM state (IDLE / BUSY)
//   winner_t - which requester owns the current adaptor transaction
//   line_t   - one 256-bit cache line
// Also provides line_base(), which aligns a byte address to its 32-byte line.
// ---------------------------------------------------------------------------
package cline_arb_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        W_NONE = 2'd0,
        W_INST = 2'd1,
        W_DATA = 2'd2,
        W_PF   = 2'd3
    } winner_t;

    typedef logic [255:0] line_t;

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    // A line is 32 bytes, so the low five address bits never reach the adaptor.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Two-requester round-robin picker (data vs instruction side).
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   req_d, req_i   - data / instruction requests
//   en             - a grant from this picker is being taken this cycle;
//                    only then does the pointer move
//   gnt_d, gnt_i   - one-hot (or zero) grant, combinational
// After reset the data side wins a tie.
// ---------------------------------------------------------------------------
module rr_pick2 (
    input  logic clk,
    input  logic reset_n,
    input  logic req_d,
    input  logic req_i,
    input  logic en,
    output logic gnt_d,
    output logic gnt_i
);

    // Set when the instruction side holds priority for the next tie,
    // i.e. the data side was granted most recently.
    logic ptr_i;

    always_comb begin
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        if (req_d && req_i) begin
            gnt_i = ptr_i;
            gnt_d = !ptr_i;
        end else begin
            gnt_d = req_d;
            gnt_i = req_i;
        end
    end

    // Any granted side (tie or sole requester) becomes "granted last".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_i <= 1'b0;
        end else if (en && (gnt_d || gnt_i)) begin
            ptr_i <= gnt_d;
        end
    end

endmodule

// File: rtl/cline_scheduler.sv
// ---------------------------------------------------------------------------
// cline_scheduler
// Arbitrates instruction, data and prefetch line requests onto a single
// cacheline adaptor, one transaction outstanding at a time.
// Ports:
//   clk, reset_n                  - clock, asynchronous active-low reset
//   i_read, i_addr                - instruction line read request
//   i_resp, i_rdata               - instruction completion / line data
//   d_read, d_write, d_addr,
//   d_wdata                       - data line request (read xor write)
//   d_resp, d_rdata               - data completion / line data
//   pf_req, pf_addr, pf_done      - prefetch read request / completion
//   cl_read, cl_write, cl_addr,
//   cl_wdata                      - registered command toward the adaptor
//   cl_rdata, cl_resp             - adaptor read data / completion
// Parameter AGE_LIMIT: lost IDLE decisions after which a waiting prefetch
// jumps the queue.
// Build option: define ARB_AGING_EN to enable prefetch aging; without it
// prefetch is strictly lowest priority and AGE_LIMIT has no effect.
// ---------------------------------------------------------------------------
module cline_scheduler
    import cline_arb_pkg::*;
#(
    parameter int AGE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic        i_resp,
    output line_t       i_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  line_t       d_wdata,
    output logic        d_resp,
    output line_t       d_rdata,
    input  logic        pf_req,
    input  logic [31:0] pf_addr,
    output logic        pf_done,
    output logic        cl_read,
    output logic        cl_write,
    output logic [31:0] cl_addr,
    output line_t       cl_wdata,
    input  line_t       cl_rdata,
    input  logic        cl_resp
);

    state_t      state;
    winner_t     owner;     // requester that owns the transaction in flight
    winner_t     win;       // IDLE-cycle arbitration result
    logic        merge;     // instruction read rides on the in-flight prefetch
    logic        d_req;
    logic        aged;
    logic        idle;
    logic        done;
    logic        merge_hit;
    logic        rr_en;
    logic        rr_gnt_d;
    logic        rr_gnt_i;
    logic [31:0] win_addr;
    logic        win_wr;

    assign d_req = d_read || d_write;
    assign idle  = (state == S_IDLE);

    // -----------------------------------------------------------------------
    // Prefetch aging
    // -----------------------------------------------------------------------
`ifdef ARB_AGING_EN
    localparam int AW = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

    logic [AW-1:0] age_cnt;

    assign aged = pf_req && (age_cnt >= AGE_MAX);

    // Counts IDLE decisions the waiting prefetch lost; saturates so a long
    // i/d storm cannot wrap it back to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            age_cnt <= '0;
        end else if (!pf_req) begin
            age_cnt <= '0;
        end else if (idle && (win == W_PF)) begin
            age_cnt <= '0;
        end else if (idle && (win != W_NONE) && (age_cnt < AGE_MAX)) begin
            age_cnt <= age_cnt + 1'b1;
        end
    end
`else
    logic age_unused;
    assign age_unused = ^AGE_LIMIT;
    assign aged       = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    // The picker pointer must not move when an aged prefetch takes the slot.
    assign rr_en = idle && !aged;

    rr_pick2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req_d   (d_req),
        .req_i   (i_read),
        .en      (rr_en),
        .gnt_d   (rr_gnt_d),
        .gnt_i   (rr_gnt_i)
    );

    always_comb begin
        win = W_NONE;
        if (aged) begin
            win = W_PF;
        end else if (rr_gnt_d) begin
            win = W_DATA;
        end else if (rr_gnt_i) begin
            win = W_INST;
        end else if (pf_req) begin
            win = W_PF;
        end
    end

    always_comb begin
        win_addr = pf_addr;
        case (win)
            W_INST:  win_addr = i_addr;
            W_DATA:  win_addr = d_addr;
            default: win_addr = pf_addr;
        endcase
    end

    assign win_wr = (win == W_DATA) && d_write;

    // An instruction read to the same line as the in-flight prefetch is
    // served by that prefetch instead of issuing a second adaptor read.
    assign merge_hit = (state == S_BUSY) && (owner == W_PF) && i_read &&
                       (i_addr[31:5] == cl_addr[31:5]);

    // -----------------------------------------------------------------------
    // FSM and registered adaptor command
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            owner    <= W_NONE;
            merge    <= 1'b0;
            cl_read  <= 1'b0;
            cl_write <= 1'b0;
            cl_addr  <= '0;
            cl_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win != W_NONE) begin
                        state    <= S_BUSY;
                        owner    <= win;
                        cl_addr  <= line_base(win_addr);
                        cl_read  <= !win_wr;
                        cl_write <= win_wr;
                        cl_wdata <= win_wr ? d_wdata : '0;
                    end
                end
                S_BUSY: begin
                    if (merge_hit) begin
                        merge <= 1'b1;
                    end
                    // Completion takes precedence: the flag never outlives
                    // the transaction it was attached to.
                    if (cl_resp) begin
                        state    <= S_IDLE;
                        owner    <= W_NONE;
                        merge    <= 1'b0;
                        cl_read  <= 1'b0;
                        cl_write <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Completion strobes (same cycle as cl_resp)
    // -----------------------------------------------------------------------
    assign done    = (state == S_BUSY) && cl_resp;
    assign d_resp  = done && (owner == W_DATA);
    assign pf_done = done && (owner == W_PF);
    assign i_resp  = done && ((owner == W_INST) || ((owner == W_PF) && merge));

    // Gated so the data buses read zero while nobody is being answered.
    assign i_rdata = i_resp ? cl_rdata : '0;
    assign d_rdata = d_resp ? cl_rdata : '0;

endmodule

// File: tb/tb_cline_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cline_scheduler
// Directed bench for cline_scheduler with a transaction-level reference model
// and a per-cycle compare process. Honours ARB_AGING_EN when defined.
// ---------------------------------------------------------------------------
module tb_cline_scheduler;
    import cline_arb_pkg::*;

    localparam int AGE_LIMIT = 8;
`ifdef ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif
    localparam int O_NONE = 0, O_INST = 1, O_DATA = 2, O_PF = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_read = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_resp;
    line_t       i_rdata;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    line_t       d_wdata = '0;
    logic        d_resp;
    line_t       d_rdata;
    logic        pf_req = 1'b0;
    logic [31:0] pf_addr = '0;
    logic        pf_done;
    logic        cl_read;
    logic        cl_write;
    logic [31:0] cl_addr;
    line_t       cl_wdata;
    line_t       cl_rdata = '0;
    logic        cl_resp = 1'b0;

    always #5 clk = ~clk;

    cline_scheduler #(.AGE_LIMIT(AGE_LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done),
        .cl_read(cl_read), .cl_write(cl_write), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
        .cl_rdata(cl_rdata), .cl_resp(cl_resp)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic line_t mk_data(input logic [31:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    // -----------------------------------------------------------------------
    // Reference model: one transaction in flight, granted by the priority
    // rules, completion on the adaptor response.
    // -----------------------------------------------------------------------
    bit          m_busy = 0, m_merge = 0, m_rd = 0, m_wr = 0;
    int          m_owner = O_NONE;
    int          m_last = O_INST;   // "granted last" = inst, so data wins first tie
    int          m_age = 0;
    logic [31:0] m_addr = '0;
    line_t       m_wdata = '0;
    int          m_log[$];

    always @(posedge clk or negedge reset_n) begin
        int pick;
        bit dreq;
        if (!reset_n) begin
            m_busy = 0; m_merge = 0; m_rd = 0; m_wr = 0;
            m_owner = O_NONE; m_last = O_INST; m_age = 0;
        end else if (!m_busy) begin
            dreq = d_read || d_write;
            pick = O_NONE;
            if (AGING && pf_req && m_age >= AGE_LIMIT) pick = O_PF;
            else if (i_read && dreq) pick = (m_last == O_DATA) ? O_INST : O_DATA;
            else if (i_read)         pick = O_INST;
            else if (dreq)           pick = O_DATA;
            else if (pf_req)         pick = O_PF;
            if (!pf_req || pick == O_PF) m_age = 0;
            else if (pick != O_NONE && m_age < AGE_LIMIT) m_age++;
            if (pick != O_NONE) begin
                m_log.push_back(pick);
                m_busy  = 1;
                m_owner = pick;
                if (pick == O_INST || pick == O_DATA) m_last = pick;
                case (pick)
                    O_INST:  m_addr = i_addr;
                    O_DATA:  m_addr = d_addr;
                    default: m_addr = pf_addr;
                endcase
                m_addr  = {m_addr[31:5], 5'b0};
                m_wr    = (pick == O_DATA) && d_write;
                m_rd    = !m_wr;
                m_wdata = d_wdata;
            end
        end else begin
            if (!pf_req) m_age = 0;
            if (m_owner == O_PF && i_read && i_addr[31:5] == m_addr[31:5]) m_merge = 1;
            if (cl_resp) begin
                m_busy = 0; m_merge = 0; m_rd = 0; m_wr = 0; m_owner = O_NONE;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        bit ei, ed, ep;
        ep = m_busy && cl_resp && (m_owner == O_PF);
        ed = m_busy && cl_resp && (m_owner == O_DATA);
        ei = m_busy && cl_resp && (m_owner == O_INST || (m_owner == O_PF && m_merge));
        chk("cl_read", cl_read, m_rd);
        chk("cl_write", cl_write, m_wr);
        chk("i_resp", i_resp, ei);
        chk("d_resp", d_resp, ed);
        chk("pf_done", pf_done, ep);
        if (m_busy) chk("cl_addr", cl_addr, m_addr);
        if (m_wr)   chk("cl_wdata", cl_wdata, m_wdata);
        if (ei)     chk("i_rdata", i_rdata, cl_rdata);
        if (ed)     chk("d_rdata", d_rdata, cl_rdata);
    end

    // -----------------------------------------------------------------------
    // Stimulus: adaptor responder + requesters, all driven from tick().
    // -----------------------------------------------------------------------
    int          ad_lat = 2, ad_cnt = 0, cyc = 0;
    bit          rep_i = 0, rep_d = 0;
    bit          s_i, s_d, s_pf, prev_rd = 0;
    int          n_rd_start = 0, n_i = 0, n_both = 0;
    logic [31:0] rd_addr_seen = '0;
    line_t       i_data_seen = '0;

    task automatic tick();
        @(negedge clk);
        s_i = i_resp; s_d = d_resp; s_pf = pf_done;
        if (cl_read && !prev_rd) n_rd_start++;
        prev_rd = cl_read;
        if (cl_read) rd_addr_seen = cl_addr;
        if (s_i) begin n_i++; i_data_seen = i_rdata; end
        if (s_i && s_pf) n_both++;
        @(posedge clk);
        #1;
        cyc++;
        if (cl_resp) begin
            cl_resp = 1'b0;
        end else if (cl_read || cl_write) begin
            ad_cnt++;
            if (ad_cnt >= ad_lat) begin
                ad_cnt   = 0;
                cl_resp  = 1'b1;
                cl_rdata = mk_data(cl_addr);
            end
        end
        if (s_i && !rep_i) i_read = 1'b0;
        if (s_d && !rep_d) begin d_read = 1'b0; d_write = 1'b0; end
        if (s_pf) pf_req = 1'b0;
    endtask

    task automatic wait_quiet(input int bound);
        int n = 0;
        while ((i_read || d_read || d_write || pf_req || cl_read || cl_write || cl_resp) && n < bound) begin
            tick();
            n++;
        end
        chk("quiet_in_time", n < bound, 1'b1);
    endtask

    int base, start;
    int exp032[4];
    int exp_age[9];

    initial begin
        exp032 = '{O_DATA, O_INST, O_DATA, O_INST};
`ifdef ARB_AGING_EN
        exp_age = '{O_DATA, O_INST, O_DATA, O_INST, O_DATA, O_INST, O_DATA, O_INST, O_PF};
`else
        exp_age = '{O_DATA, O_INST, O_DATA, O_INST, O_DATA, O_INST, O_DATA, O_INST, O_DATA};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cl_read", cl_read, 1'b0);
        chk("rst_cl_write", cl_write, 1'b0);
        chk("rst_cl_addr", cl_addr, 32'h0);
        chk("rst_resps", {i_resp, d_resp, pf_done}, 3'b000);
        reset_n = 1'b1;
        tick();

        // Single instruction read, adaptor answers 4 cycles after cl_read
        ad_lat = 4; ad_cnt = 0; n_i = 0; n_rd_start = 0;
        start = cyc;
        i_addr = 32'h6000_0044; i_read = 1'b1;
        while (n_i == 0 && cyc - start < 20) tick();
        chk("t031_latency", cyc - start, 5);
        chk("t031_cl_addr", rd_addr_seen, 32'h6000_0040);
        chk("t031_rdata", i_data_seen, mk_data(32'h6000_0040));
        wait_quiet(20);
        repeat (3) tick();
        chk("t031_pulses", n_i, 1);
        chk("t031_ops", n_rd_start, 1);

        // cl_resp while idle must be ignored
        cl_resp = 1'b1;
        tick();
        chk("idle_cl_resp", {s_i, s_d, s_pf}, 3'b000);

        // i_read and d_write together, twice: D, I, D, I
        ad_lat = 2; ad_cnt = 0;
        base = m_log.size();
        i_addr = 32'h2000_0000;
        d_addr = 32'h1000_0024; d_wdata = {8{32'hDEAD_0001}};
        i_read = 1'b1; d_write = 1'b1;
        wait_quiet(60);
        d_wdata = {8{32'hBEEF_0002}};
        i_read = 1'b1; d_write = 1'b1;
        wait_quiet(60);
        chk("t032_count", m_log.size() - base, 4);
        for (int k = 0; k < 4; k++) chk("t032_order", m_log[base + k], exp032[k]);

        // i/d saturate while prefetch waits
        ad_lat = 1; ad_cnt = 0;
        base = m_log.size();
        pf_addr = 32'h5000_0000; i_addr = 32'h2000_0040; d_addr = 32'h1000_0080;
        rep_i = 1; rep_d = 1;
        i_read = 1'b1; d_read = 1'b1; pf_req = 1'b1;
        start = 0;
        while (m_log.size() - base < 9 && start < 200) begin tick(); start++; end
        rep_i = 0; rep_d = 0;
        wait_quiet(200);
        chk("age_decisions", m_log.size() - base >= 9, 1'b1);
        for (int k = 0; k < 9; k++) chk("age_order", m_log[base + k], exp_age[k]);

        // Prefetch 0x100 in flight, i_read 0x11C merges into it
        ad_lat = 4; ad_cnt = 0; n_rd_start = 0; n_both = 0; n_i = 0;
        base = m_log.size();
        pf_addr = 32'h0000_0100; pf_req = 1'b1;
        tick();
        i_addr = 32'h0000_011C; i_read = 1'b1;
        wait_quiet(40);
        repeat (3) tick();
        chk("t034_cl_reads", n_rd_start, 1);
        chk("t034_same_cycle", n_both, 1);
        chk("t034_i_pulses", n_i, 1);
        chk("t034_grants", m_log.size() - base, 1);

        // Reset during a data write
        ad_lat = 6; ad_cnt = 0;
        d_addr = 32'h7000_0010; d_wdata = {8{32'h0BAD_F00D}}; d_write = 1'b1;
        tick();
        tick();
        chk("t035_pre_write", cl_write, 1'b1);
        #2;
        reset_n = 1'b0; d_write = 1'b0; cl_resp = 1'b0; ad_cnt = 0;
        #1;
        chk("t035_async_write", cl_write, 1'b0);
        chk("t035_async_addr", cl_addr, 32'h0);
        i_addr = 32'h3000_0008; i_read = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("t035_cl_read", cl_read, 1'b1);
        chk("t035_cl_addr", cl_addr, 32'h3000_0000);
        wait_quiet(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
